battleship_board: RTL and testbench

// - Per-player board datapath; the responder to the game-control FSM's load strobes.
// - Stores one player's ship map and the opponent's accumulated shots.
// - Validates each new shot and reports it to the FSM through ok_shot, combinationally
//   in the same cycle, because the FSM samples it in its attack state.
// - Commits accepted shots, counts remaining ship cells, drives alive, and exposes
//   hit/miss/error status for the display mux.
// - One instance per player.

---
 rtl/bs_pkg.sv | 23 ++
 rtl/shot_validator.sv | 19 +
 rtl/battleship_board.sv | 113 +++++++++++
 tb/tb_battleship_board.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared types and helpers for the battleship board datapath.
package bs_pkg;

  localparam int unsigned CELLS_DEFAULT = 16;
  // Widest board popcount can handle; callers zero-extend into this width.
  localparam int unsigned POP_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SUNK
  } board_st_t;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/shot_validator.sv
// Combinational legality check for a cumulative shot map: exactly one newly
// added cell and no previously fired cell withdrawn.
module shot_validator
  import bs_pkg::*;
#(
  parameter int unsigned CELLS = CELLS_DEFAULT
) (
  input  logic [CELLS-1:0] sw,
  input  logic [CELLS-1:0] shot_map,
  output logic             ok_shot,
  output logic [CELLS-1:0] new_cell
);

  always_comb begin
    new_cell = sw & ~shot_map;
    ok_shot  = (popcount(POP_MAX'(new_cell)) == 1) && ((sw & shot_map) == shot_map);
  end

endmodule

// File: rtl/battleship_board.sv
// One player's board: ship map, accumulated opponent shots, remaining-cell
// counter, hit status and a hold timer for the rejected-shot flag.
module battleship_board
  import bs_pkg::*;
#(
  parameter int unsigned CELLS      = CELLS_DEFAULT,
  parameter int unsigned ERR_CYCLES = 50000000
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       ld_ships,
  input  logic                       ld_shot,
  input  logic [CELLS-1:0]           sw,
  output logic                       ok_shot,
  output logic                       alive,
  output logic                       hit,
  output logic                       err_flag,
  output logic [CELLS-1:0]           ship_map,
  output logic [CELLS-1:0]           shot_map,
  output logic [$clog2(CELLS+1)-1:0] remaining
);

  localparam int unsigned RW = $clog2(CELLS + 1);
  localparam int unsigned EW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

  board_st_t      state_q, state_d;
  logic [CELLS-1:0] ship_q, ship_d;
  logic [CELLS-1:0] shot_q, shot_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic           hit_q, hit_d;
  logic           err_q, err_d;
  logic [EW-1:0]  cnt_q, cnt_d;

  logic [CELLS-1:0] new_cell;
  logic             hit_cell;
  logic [RW-1:0]    ship_cnt;

  shot_validator #(.CELLS(CELLS)) u_val (
    .sw       (sw),
    .shot_map (shot_q),
    .ok_shot  (ok_shot),
    .new_cell (new_cell)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      ship_q  <= '0;
      shot_q  <= '0;
      rem_q   <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ship_q  <= ship_d;
      shot_q  <= shot_d;
      rem_q   <= rem_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ship_d   = ship_q;
    shot_d   = shot_q;
    rem_d    = rem_q;
    hit_d    = hit_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    hit_cell = |(new_cell & ship_q);
    ship_cnt = RW'(popcount(POP_MAX'(sw)));

    if (ld_ships) begin
      ship_d  = sw;
      shot_d  = '0;
      rem_d   = ship_cnt;
      hit_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
      state_d = (ship_cnt == '0) ? SUNK : ARMED;
    end else begin
      if (ld_shot && ok_shot) begin
        shot_d = sw;
        hit_d  = hit_cell;
        // Only an armed board with cells left may count down.
        if (hit_cell && (state_q == ARMED) && (rem_q != '0)) begin
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = SUNK;
        end
      end
      // Flag drops on the edge after the counter has already run down to zero.
      if (ld_shot && !ok_shot) begin
        err_d = 1'b1;
        cnt_d = EW'(ERR_CYCLES - 1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - EW'(1);
      end else begin
        err_d = 1'b0;
      end
    end
  end

  assign alive     = (state_q != IDLE) && (rem_q != '0);
  assign hit       = hit_q;
  assign err_flag  = err_q;
  assign ship_map  = ship_q;
  assign shot_map  = shot_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_battleship_board.sv
// Scoreboard bench for battleship_board with CELLS=16, ERR_CYCLES=4.
module tb_battleship_board;

  logic        clk = 1'b0;
  logic        clr;
  logic        ld_ships;
  logic        ld_shot;
  logic [15:0] sw;
  logic        ok_shot;
  logic        alive;
  logic        hit;
  logic        err_flag;
  logic [15:0] ship_map;
  logic [15:0] shot_map;
  logic [4:0]  remaining;

  battleship_board #(.CELLS(16), .ERR_CYCLES(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .ld_ships  (ld_ships),
    .ld_shot   (ld_shot),
    .sw        (sw),
    .ok_shot   (ok_shot),
    .alive     (alive),
    .hit       (hit),
    .err_flag  (err_flag),
    .ship_map  (ship_map),
    .shot_map  (shot_map),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ship;
    logic [15:0] shot;
    logic [4:0]  rem;
    logic        alive;
    logic        hit;
    logic        err;
  } snap_t;

  snap_t       sb[$];
  snap_t       e_s, a_s;
  int unsigned tests = 0;
  int unsigned fails = 0;

  function automatic snap_t snap();
    snap_t s;
    s.ship  = ship_map;
    s.shot  = shot_map;
    s.rem   = remaining;
    s.alive = alive;
    s.hit   = hit;
    s.err   = err_flag;
    return s;
  endfunction

  function automatic snap_t mk(input logic [15:0] ship, input logic [15:0] shot,
                               input logic [4:0] rem, input logic al,
                               input logic h, input logic er);
    snap_t s;
    s.ship = ship; s.shot = shot; s.rem = rem; s.alive = al; s.hit = h; s.err = er;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; ld_ships = 1'b0; ld_shot = 1'b0; sw = '0;
    sb.push_back(mk(16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0));
    tick();
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL reset act=%h exp=%h", a_s, e_s); end
    tests++;
    if (ok_shot !== 1'b0) begin fails++; $display("FAIL reset_ok act=%b exp=0", ok_shot); end
    clr = 1'b0;
  endtask

  task automatic test_ship_load();
    sw = 16'h0013; ld_ships = 1'b1;
    sb.push_back(mk(16'h0013, 16'h0, 5'd3, 1'b1, 1'b0, 1'b0));
    tick();
    ld_ships = 1'b0; sw = '0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL ship_load act=%h exp=%h", a_s, e_s); end
    #1; tests++;
    if (ok_shot !== 1'b0) begin fails++; $display("FAIL ship_load_ok act=%b exp=0", ok_shot); end
  endtask

  task automatic test_hit_miss();
    logic [15:0] sws [2];
    snap_t       exps[2];
    sws[0] = 16'h0001; exps[0] = mk(16'h0013, 16'h0001, 5'd2, 1'b1, 1'b1, 1'b0);
    sws[1] = 16'h0009; exps[1] = mk(16'h0013, 16'h0009, 5'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sw = sws[i]; #1; tests++;
      if (ok_shot !== 1'b1) begin fails++; $display("FAIL hit_miss_ok[%0d] act=%b exp=1", i, ok_shot); end
      ld_shot = 1'b1; sb.push_back(exps[i]);
      tick(); ld_shot = 1'b0;
      e_s = sb.pop_front(); a_s = snap(); tests++;
      if (a_s !== e_s) begin fails++; $display("FAIL hit_miss[%0d] act=%h exp=%h", i, a_s, e_s); end
    end
  endtask

  task automatic test_illegal();
    // Two new cells at once.
    sw = 16'h000F; #1; tests++;
    if (ok_shot !== 1'b0) begin fails++; $display("FAIL two_new_ok act=%b exp=0", ok_shot); end
    ld_shot = 1'b1; sb.push_back(mk(16'h0013, 16'h0009, 5'd2, 1'b1, 1'b0, 1'b1));
    tick(); ld_shot = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL two_new act=%h exp=%h", a_s, e_s); end
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk(16'h0013, 16'h0009, 5'd2, 1'b1, 1'b0, k < 3));
      tick();
      e_s = sb.pop_front(); a_s = snap(); tests++;
      if (a_s !== e_s) begin fails++; $display("FAIL err_hold[%0d] act=%h exp=%h", k, a_s, e_s); end
    end
    // Withdrawn shot, then a second reject while the flag is held.
    sw = 16'h0008; #1; tests++;
    if (ok_shot !== 1'b0) begin fails++; $display("FAIL withdrawn_ok act=%b exp=0", ok_shot); end
    ld_shot = 1'b1; sb.push_back(mk(16'h0013, 16'h0009, 5'd2, 1'b1, 1'b0, 1'b1));
    tick(); ld_shot = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL withdrawn act=%h exp=%h", a_s, e_s); end
    for (int i = 0; i < 7; i++) begin
      ld_shot = (i == 2);
      sb.push_back(mk(16'h0013, 16'h0009, 5'd2, 1'b1, 1'b0, i < 6));
      tick(); ld_shot = 1'b0;
      e_s = sb.pop_front(); a_s = snap(); tests++;
      if (a_s !== e_s) begin fails++; $display("FAIL err_reload[%0d] act=%h exp=%h", i, a_s, e_s); end
    end
  endtask

  task automatic test_sink();
    logic [15:0] sws [3];
    snap_t       exps[3];
    sws[0] = 16'h000B; exps[0] = mk(16'h0013, 16'h000B, 5'd1, 1'b1, 1'b1, 1'b0);
    sws[1] = 16'h001B; exps[1] = mk(16'h0013, 16'h001B, 5'd0, 1'b0, 1'b1, 1'b0);
    sws[2] = 16'h003B; exps[2] = mk(16'h0013, 16'h003B, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sw = sws[i]; #1; tests++;
      if (ok_shot !== 1'b1) begin fails++; $display("FAIL sink_ok[%0d] act=%b exp=1", i, ok_shot); end
      ld_shot = 1'b1; sb.push_back(exps[i]);
      tick(); ld_shot = 1'b0;
      e_s = sb.pop_front(); a_s = snap(); tests++;
      if (a_s !== e_s) begin fails++; $display("FAIL sink[%0d] act=%h exp=%h", i, a_s, e_s); end
    end
  endtask

  task automatic test_held_strobe();
    sw = 16'h0003; ld_ships = 1'b1;
    sb.push_back(mk(16'h0003, 16'h0, 5'd2, 1'b1, 1'b0, 1'b0));
    tick(); ld_ships = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL held_load act=%h exp=%h", a_s, e_s); end
    sw = 16'h0001; ld_shot = 1'b1;
    sb.push_back(mk(16'h0003, 16'h0001, 5'd1, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(16'h0003, 16'h0001, 5'd1, 1'b1, 1'b1, 1'b1));
    for (int i = 0; i < 2; i++) begin
      tick();
      e_s = sb.pop_front(); a_s = snap(); tests++;
      if (a_s !== e_s) begin fails++; $display("FAIL held[%0d] act=%h exp=%h", i, a_s, e_s); end
      if (i == 0) begin
        tests++;
        if (ok_shot !== 1'b0) begin fails++; $display("FAIL held_ok act=%b exp=0", ok_shot); end
      end
    end
    ld_shot = 1'b0;
  endtask

  task automatic test_both_strobes();
    sw = 16'h0005; ld_ships = 1'b1; ld_shot = 1'b1;
    sb.push_back(mk(16'h0005, 16'h0, 5'd2, 1'b1, 1'b0, 1'b0));
    tick(); ld_ships = 1'b0; ld_shot = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL both act=%h exp=%h", a_s, e_s); end
  endtask

  task automatic test_async_reset();
    sw = 16'h0004; ld_shot = 1'b1;
    sb.push_back(mk(16'h0005, 16'h0004, 5'd1, 1'b1, 1'b1, 1'b0));
    tick(); ld_shot = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL pre_clr act=%h exp=%h", a_s, e_s); end
    #2; clr = 1'b1;
    sb.push_back(mk(16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0));
    #1;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL async_clr act=%h exp=%h", a_s, e_s); end
    sw = 16'hFFFF; ld_ships = 1'b1;
    sb.push_back(mk(16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0));
    tick(); ld_ships = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL clr_held act=%h exp=%h", a_s, e_s); end
    #2; clr = 1'b0;
    sw = 16'h0000; ld_ships = 1'b1;
    sb.push_back(mk(16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0));
    tick(); ld_ships = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL empty_load act=%h exp=%h", a_s, e_s); end
    sw = 16'h0001; ld_shot = 1'b1;
    sb.push_back(mk(16'h0, 16'h0001, 5'd0, 1'b0, 1'b0, 1'b0));
    tick(); ld_shot = 1'b0;
    e_s = sb.pop_front(); a_s = snap(); tests++;
    if (a_s !== e_s) begin fails++; $display("FAIL empty_shot act=%h exp=%h", a_s, e_s); end
  endtask

  initial begin
    test_reset();
    test_ship_load();
    test_hit_miss();
    test_illegal();
    test_sink();
    test_held_strobe();
    test_both_strobes();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
